// File: rtl/pwm_dual_out.sv
// Edge-aligned PWM with a complementary dead-time-protected low-side output.
// Outputs are registered one cycle after the compare; duty updates only at the period wrap.
module pwm_dual_out #(
    parameter int PERIOD = 100,
    parameter int DEAD   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] dc,
    output logic       pwm_out,
    output logic       pwm_out1
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);
    localparam logic [6:0]    PER7    = 7'(PERIOD);
    localparam logic [7:0]    DEAD8   = 8'(DEAD);
    localparam logic [7:0]    LO_END8 = 8'(PERIOD - DEAD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    duty_q, duty_d;
    logic          pwm_out_q, pwm_out_d;
    logic          pwm_out1_q, pwm_out1_d;

    logic [7:0]    cnt8;
    logic [7:0]    duty8;
    logic [7:0]    lo_start8;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        duty_d = duty_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            // Clamp so out-of-range commands behave as 100% rather than wrapping.
            duty_d = (dc > PER7) ? PER7 : dc;
        end
    end

    always_comb begin
        cnt8       = {{(8 - CW){1'b0}}, cnt_q};
        duty8      = {1'b0, duty_q};
        lo_start8  = duty8 + DEAD8;
        pwm_out_d  = (cnt8 < duty8);
        pwm_out1_d = (cnt8 >= lo_start8) && (cnt8 < LO_END8);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            duty_q     <= '0;
            pwm_out_q  <= 1'b0;
            pwm_out1_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            pwm_out_q  <= pwm_out_d;
            pwm_out1_q <= pwm_out1_d;
        end
    end

    assign pwm_out  = pwm_out_q;
    assign pwm_out1 = pwm_out1_q;

endmodule

// File: tb/tb_pwm_dual_out.sv
// Bench for pwm_dual_out: per-cycle reference from elapsed-cycle arithmetic,
// per-period pulse-width table, and mid-period / reset corner sequences.
module tb_pwm_dual_out;

    localparam int P = 100;
    localparam int D = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] dc = 7'd0;
    logic       pwm_out;
    logic       pwm_out1;

    pwm_dual_out #(.PERIOD(P), .DEAD(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .dc       (dc),
        .pwm_out  (pwm_out),
        .pwm_out1 (pwm_out1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: edges since reset, position of the output in its period, active duty.
    int n = 0;
    int pos = 0;
    int cur_duty = 0;
    int hi_acc = 0, lo_acc = 0;
    int done_hi = 0, done_lo = 0;
    bit period_done = 0;
    int both_low = 1000;
    logic prev_o = 0, prev_o1 = 0;

    typedef struct {
        int dc_val;
        int exp_hi;
        int exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d pos %0d)", name, act, exp_v, n, pos);
        end
    endtask

    task automatic tick();
        int eo, eo1, exp_lo;
        @(posedge clk);
        #1;
        if (reset) begin
            n = 0;
            pos = 0;
            cur_duty = 0;
            hi_acc = 0;
            lo_acc = 0;
            eo = 0;
            eo1 = 0;
            chk("pwm_out_reset", int'(pwm_out), eo);
            chk("pwm_out1_reset", int'(pwm_out1), eo1);
            both_low = 1000;
        end else begin
            n++;
            pos = (n - 1) % P;
            eo  = (pos < cur_duty) ? 1 : 0;
            eo1 = (pos >= cur_duty + D && pos < P - D) ? 1 : 0;
            chk("pwm_out", int'(pwm_out), eo);
            chk("pwm_out1", int'(pwm_out1), eo1);
            chk("overlap", int'(pwm_out & pwm_out1), 0);
            if ((pwm_out && !prev_o) || (pwm_out1 && !prev_o1))
                chk("dead_gap", (both_low >= D) ? 1 : 0, 1);
            both_low = (!pwm_out && !pwm_out1) ? both_low + 1 : 0;
            hi_acc += int'(pwm_out);
            lo_acc += int'(pwm_out1);
            if (pos == P - 1) begin
                exp_lo = P - cur_duty - 2 * D;
                if (exp_lo < 0) exp_lo = 0;
                chk("period_hi", hi_acc, cur_duty);
                chk("period_lo", lo_acc, exp_lo);
                done_hi = hi_acc;
                done_lo = lo_acc;
                period_done = 1;
                hi_acc = 0;
                lo_acc = 0;
                cur_duty = (int'(dc) > P) ? P : int'(dc);
            end
        end
        prev_o  = pwm_out;
        prev_o1 = pwm_out1;
    endtask

    task automatic wait_period(input string name);
        bit ok;
        ok = 0;
        period_done = 0;
        for (int i = 0; i < 2 * P + 2; i++) begin
            tick();
            if (period_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int first_lo, last_lo;

        vecs[0]  = '{0,   0,   96};
        vecs[1]  = '{25,  25,  71};
        vecs[2]  = '{50,  50,  46};
        vecs[3]  = '{75,  75,  21};
        vecs[4]  = '{100, 100, 0};
        vecs[5]  = '{120, 100, 0};
        vecs[6]  = '{97,  97,  0};
        vecs[7]  = '{127, 100, 0};
        vecs[8]  = '{1,   1,   95};
        vecs[9]  = '{95,  95,  1};
        vecs[10] = '{96,  96,  0};

        reset = 1'b1;
        dc = 7'd0;
        repeat (3) tick();
        reset = 1'b0;

        // First period after reset always runs at duty 0, even with dc nonzero.
        dc = 7'd60;
        wait_period("first");
        chk("first_hi", done_hi, 0);
        chk("first_lo", done_lo, 96);

        for (int i = 0; i < 11; i++) begin
            dc = 7'(vecs[i].dc_val);
            wait_period("latch");
            wait_period("measure");
            chk($sformatf("vec%0d_hi", i), done_hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), done_lo, vecs[i].exp_lo);
        end

        // Mid-period change: current period keeps duty 0, next uses 25.
        dc = 7'd0;
        wait_period("mid_a");
        repeat (50) tick();
        dc = 7'd25;
        wait_period("mid_b");
        chk("mid_cur_hi", done_hi, 0);
        chk("mid_cur_lo", done_lo, 96);
        period_done = 0;
        first_lo = -1;
        last_lo = -1;
        for (int i = 0; i < P && !period_done; i++) begin
            tick();
            if (pwm_out1) begin
                if (first_lo < 0) first_lo = pos;
                last_lo = pos;
            end
        end
        chk("mid_lo_first_cnt", first_lo, 27);
        chk("mid_lo_last_cnt", last_lo, 97);
        chk("mid_next_hi", done_hi, 25);

        // Reset asserted at cnt = 40 with duty 50 active.
        dc = 7'd50;
        wait_period("rst_a");
        wait_period("rst_b");
        for (int i = 0; i < P && (n % P) != 40; i++) tick();
        chk("rst_at_cnt40", n % P, 40);
        reset = 1'b1;
        tick();
        chk("rst_pwm_out", int'(pwm_out), 0);
        chk("rst_pwm_out1", int'(pwm_out1), 0);
        reset = 1'b0;
        wait_period("rst_p1");
        chk("rst_p1_hi", done_hi, 0);
        chk("rst_p1_lo", done_lo, 96);
        wait_period("rst_p2");
        chk("rst_p2_hi", done_hi, 50);
        chk("rst_p2_lo", done_lo, 46);

        // Randomized commands, mid-period changes and occasional resets.
        for (int i = 0; i < 14; i++) begin
            dc = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 5) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                reset = 1'b0;
            end
            repeat ($urandom_range(30, 250)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_dual_out.md
Name: pwm_dual_out

Overview:
- Fixed-period, edge-aligned PWM generator with 7-bit duty command in percent (0..100).
- Drives a high-side output and a complementary low-side output with programmable dead time.
- Sits between a control register/status input and a half-bridge or LED driver stage, clocked from the system clock (nominal 256 kHz).

Parameters:
- PERIOD, 100, counter period in clock cycles. One count equals one percent of duty. Must be in the range 2..127.
- DEAD, 2, dead-time cycles inserted before and after each low-side pulse. Must satisfy 0 <= DEAD < PERIOD/2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- dc  input  7  duty command in percent (unsigned). Sampled only at period boundaries.
- pwm_out  output  1  high-side PWM, registered.
- pwm_out1  output  1  complementary low-side PWM with dead time, registered.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset state: while reset is high at a rising edge, the following are all cleared to 0:
  - cnt
  - duty_q
  - pwm_out
  - pwm_out1
- Counter cnt is ceil(log2(PERIOD)) bits wide. It increments by 1 each clock and wraps from PERIOD-1 to 0.
- Duty latch: at the edge where cnt == PERIOD-1 (wrap edge), duty_q <= min(dc, PERIOD). Values of dc above PERIOD (101..127 with the default) are clamped to PERIOD.
  - dc changes mid-period have no effect until the next wrap, so there are no glitches or runt pulses.
  - The first period after reset always uses duty 0.
- Output comparisons are evaluated on the current cnt and duty_q, then registered (1-cycle latency):
  - pwm_out <= (cnt < duty_q).
  - pwm_out1 <= (cnt >= duty_q + DEAD) && (cnt < PERIOD - DEAD). The sum is computed at least 8 bits wide, with no overflow.
- Duty per period:
  - pwm_out is high for exactly duty_q cycles per period.
  - pwm_out1 is high for max(0, PERIOD - duty_q - 2*DEAD) cycles.
- Non-overlap invariant: pwm_out and pwm_out1 are never both 1. Each low-to-high transition of either output is preceded by at least DEAD cycles with both outputs low.
  - Exception: when DEAD = 0, the outputs are exact complements outside reset.
- Boundaries:
  - duty_q = 0: pwm_out constantly 0. pwm_out1 high for cnt in [DEAD, PERIOD-DEAD).
  - duty_q = PERIOD: pwm_out constantly 1. pwm_out1 constantly 0.
  - duty_q >= PERIOD - 2*DEAD: pwm_out1 constantly 0.
- Reset mid-period: cnt, duty_q and both outputs return to 0 on the next edge, and the period restarts from cnt = 0 after release.
- Timing after reset release: on the first edge with reset low, cnt goes from 0 to 1 and the outputs reflect the cnt = 0 evaluation.
- No handshake; dc is assumed quasi-static relative to the period, and no input synchronizer is required.

Test Plan:
- Reset then dc = 0 for 3 periods -> pwm_out = 0 throughout. pwm_out1 is high 96 of every 100 cycles, low for 2 cycles at each end of the period.
- dc = 25 applied mid-period -> the current period is unchanged. From the next wrap, pwm_out is high 25 cycles per 100, and pwm_out1 is high for 71 cycles, from count 27 to 97 inclusive (pre-register cnt values).
- dc = 50, then 75 -> pwm_out high 50 and 75 cycles per period, and pwm_out1 high 46 and 21 cycles. Throughout, check that both outputs are never simultaneously 1 and that gaps are at least 2 cycles.
- dc = 100, then dc = 120 -> pwm_out stays 1 continuously across wraps, and pwm_out1 stays 0 (clamping verified).
- dc = 97 -> pwm_out high 97 cycles per period, and pwm_out1 stays 0 (dead-time boundary).
- Assert reset at cnt = 40 with dc = 50 -> both outputs 0 on the next edge. After release, the first period has both outputs per duty 0, and duty 50 applies from the second period.
